// File: rtl/finc_fdec_pulser.sv
// FINC/FDEC pulse generator: nets speed-change requests into a signed
// backlog and drains it as fixed-width pulses separated by a minimum gap.
module finc_fdec_pulser #(
   parameter int PULSE_W = 8,
   parameter int GAP_W   = 16,
   parameter int CNT_W   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   input  logic [1:0]              req_code,
   input  logic                    enable,
   input  logic                    flush,
   input  logic                    clr_ovf,
   output logic                    finc,
   output logic                    fdec,
   output logic                    busy,
   output logic signed [CNT_W-1:0] pending,
   output logic                    ovf
);

   localparam int PH_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int SW     = CNT_W + 2;
   localparam logic signed [SW-1:0] PMAX = SW'((2 ** (CNT_W - 1)) - 1);
   localparam logic signed [SW-1:0] PMIN = -PMAX;
   localparam logic signed [SW-1:0] ONE  = SW'(1);
   localparam logic [PH_W-1:0] PLS_LD = PH_W'(PULSE_W - 1);
   localparam logic [PH_W-1:0] GAP_LD = PH_W'(GAP_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      GAP
   } state_e;

   state_e                  state_q;
   logic [PH_W-1:0]         cnt_q;
   logic signed [CNT_W-1:0] pend_q, pend_d;
   logic                    finc_q, fdec_q, busy_q;
   logic                    ovf_q, ovf_d;
   logic                    start_inc, start_dec;
   logic signed [SW-1:0]    req_dl, iss_dl, sum;
   logic                    sat;

   assign start_inc = (state_q == IDLE) && enable
                      && !pend_q[CNT_W-1] && (pend_q != '0);
   assign start_dec = (state_q == IDLE) && enable && pend_q[CNT_W-1];

   // Request and issue deltas are summed together so simultaneous events net.
   always_comb begin
      req_dl = '0;
      iss_dl = '0;
      sat    = 1'b0;
      if (req_valid && req_code == 2'b01) req_dl = ONE;
      if (req_valid && req_code == 2'b10) req_dl = -ONE;
      if (start_inc) iss_dl = -ONE;
      if (start_dec) iss_dl = ONE;
      sum    = SW'(pend_q) + req_dl + iss_dl;
      pend_d = pend_q;
      if (flush) begin
         pend_d = '0;
      end else if (sum > PMAX) begin
         pend_d = CNT_W'(PMAX);
         sat    = 1'b1;
      end else if (sum < PMIN) begin
         pend_d = CNT_W'(PMIN);
         sat    = 1'b1;
      end else begin
         pend_d = CNT_W'(sum);
      end
      ovf_d = sat | (ovf_q & ~clr_ovf);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         finc_q  <= 1'b0;
         fdec_q  <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         unique case (state_q)
            IDLE: begin
               if (start_inc || start_dec) begin
                  state_q <= PULSE;
                  cnt_q   <= PLS_LD;
                  finc_q  <= start_inc;
                  fdec_q  <= start_dec;
                  busy_q  <= 1'b1;
               end
            end
            PULSE: begin
               if (cnt_q == '0) begin
                  state_q <= GAP;
                  cnt_q   <= GAP_LD;
                  finc_q  <= 1'b0;
                  fdec_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            GAP: begin
               if (cnt_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               finc_q  <= 1'b0;
               fdec_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign finc    = finc_q;
   assign fdec    = fdec_q;
   assign busy    = busy_q;
   assign pending = pend_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_finc_fdec_pulser.sv
// Bench for finc_fdec_pulser: directed scenarios plus random traffic
// against a pulse-timeline reference model.
module tb_finc_fdec_pulser;

   localparam int PW   = 8;
   localparam int GW   = 16;
   localparam int CW   = 4;
   localparam int MAXP = 7;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic req_valid = 1'b0;
   logic [1:0] req_code = 2'b00;
   logic enable = 1'b0;
   logic flush = 1'b0;
   logic clr_ovf = 1'b0;
   logic finc, fdec, busy, ovf;
   logic signed [CW-1:0] pending;

   int checks = 0;
   int errors = 0;

   int m_p, m_last, n;
   bit m_ovf, m_dir;

   always #5 clk = ~clk;

   finc_fdec_pulser #(
      .PULSE_W(PW),
      .GAP_W  (GW),
      .CNT_W  (CW)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_code (req_code),
      .enable   (enable),
      .flush    (flush),
      .clr_ovf  (clr_ovf),
      .finc     (finc),
      .fdec     (fdec),
      .busy     (busy),
      .pending  (pending),
      .ovf      (ovf)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d",
                  tag, n, got, exp);
      end
   endtask

   task automatic model_reset();
      m_p    = 0;
      m_ovf  = 0;
      m_last = -1000;
   endtask

   // Pulses are tracked by start cycle: a new one may begin only once
   // PW+GW+1 cycles have elapsed since the previous start.
   task automatic model_edge();
      int  rd, iss, s;
      bit  start, sat;
      n++;
      if (!rst) begin
         model_reset();
      end else begin
         start = (n >= m_last + PW + GW + 1) && enable && (m_p != 0);
         iss = 0;
         if (start) begin
            m_dir  = (m_p > 0);
            iss    = m_dir ? -1 : 1;
            m_last = n;
         end
         rd = 0;
         if (req_valid && req_code == 2'b01) rd = 1;
         if (req_valid && req_code == 2'b10) rd = -1;
         s   = m_p + rd + iss;
         sat = 0;
         if (s > MAXP) begin
            s = MAXP; sat = 1;
         end else if (s < -MAXP) begin
            s = -MAXP; sat = 1;
         end
         if (flush) begin
            s = 0; sat = 0;
         end
         m_ovf = sat || (m_ovf && !clr_ovf);
         m_p   = s;
      end
   endtask

   task automatic check_outs();
      bit act;
      act = (n - m_last) < PW;
      chk("finc", int'(finc), int'(act && m_dir));
      chk("fdec", int'(fdec), int'(act && !m_dir));
      chk("busy", int'(busy), int'((n - m_last) < PW + GW));
      chk("pending", int'(pending), m_p);
      chk("ovf", int'(ovf), int'(m_ovf));
      chk("excl", int'(finc && fdec), 0);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_outs();
   endtask

   task automatic rand_inputs();
      req_valid = 1'($urandom_range(0, 1));
      req_code  = 2'($urandom);
      flush     = ($urandom_range(0, 39) == 0);
      clr_ovf   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) enable = ~enable;
   endtask

   initial begin
      n = 0;
      m_dir = 1;
      model_reset();
      #12;
      check_outs();
      rst = 1'b1;

      enable = 1'b1;
      req_valid = 1'b1; req_code = 2'b01;
      cycle();
      req_valid = 1'b0;
      repeat (30) cycle();

      enable = 1'b0;
      req_valid = 1'b1; req_code = 2'b01;
      repeat (9) cycle();
      req_valid = 1'b0; clr_ovf = 1'b1;
      cycle();
      clr_ovf = 1'b0;
      req_valid = 1'b1; req_code = 2'b10;
      cycle();
      req_valid = 1'b0; flush = 1'b1;
      cycle();
      flush = 1'b0;

      req_valid = 1'b1; req_code = 2'b01;
      cycle();
      req_code = 2'b10;
      cycle();
      req_valid = 1'b0; enable = 1'b1;
      repeat (30) cycle();

      repeat (1500) begin
         rand_inputs();
         cycle();
      end

      flush = 1'b0; clr_ovf = 1'b0; req_valid = 1'b0; enable = 1'b0;
      repeat (30) cycle();
      req_valid = 1'b1; req_code = 2'b01;
      repeat (6) cycle();
      req_valid = 1'b0; enable = 1'b1;
      repeat (4) cycle();
      rst = 1'b0;
      #1;
      model_reset();
      chk("rst_finc", int'(finc), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pending", int'(pending), 0);
      cycle();
      rst = 1'b1;
      repeat (40) cycle();

      repeat (1500) begin
         rand_inputs();
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
